// File: rtl/cpu_define.sv
// Shared CPU encodings: widths and the valid/busy/null constants used by
// the ROB, dispatch and the rename register file.
package cpu_define;
  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int REG_W = 5;
  localparam int TAG_W = 4;

  localparam logic VALID   = 1'b1;
  localparam logic INVALID = 1'b0;
  localparam logic BUSY    = 1'b1;
  localparam logic READY   = 1'b0;

  localparam logic [REG_W-1:0] ZERO_REG  = '0;
  localparam logic [TAG_W-1:0] NULL_TAG  = '0;
  localparam logic [XLEN-1:0]  ZERO_DATA = '0;
endpackage

// File: rtl/rf_read_port.sv
// One combinational operand lookup: x0 guard, commit bypass, then either the
// producing tag (busy) or the stored value (ready).
module rf_read_port
  import cpu_define::*;
#(
  parameter int XLEN_P  = XLEN,
  parameter int NREG_P  = NREG,
  parameter int REG_W_P = REG_W,
  parameter int TAG_W_P = TAG_W
) (
  input  logic [REG_W_P-1:0]              addr,
  input  logic [NREG_P-1:0]               reg_busy,
  input  logic [NREG_P-1:0][TAG_W_P-1:0]  reg_tag,
  input  logic [NREG_P-1:0][XLEN_P-1:0]   reg_data,
  input  logic                            commit_valid,
  input  logic [REG_W_P-1:0]              commit_rd,
  input  logic [TAG_W_P-1:0]              commit_tag,
  input  logic [XLEN_P-1:0]               commit_data,
  output logic                            busy,
  output logic [TAG_W_P-1:0]              tag,
  output logic [XLEN_P-1:0]               data
);
  logic hit;
  assign hit = commit_valid && (commit_rd == addr) && reg_busy[addr] &&
               (reg_tag[addr] == commit_tag);

  always_comb begin
    busy = READY;
    tag  = '0;
    data = '0;
    if (addr != '0) begin
      if (hit) begin
        data = commit_data;
      end else if (reg_busy[addr]) begin
        busy = BUSY;
        tag  = reg_tag[addr];
      end else begin
        data = reg_data[addr];
      end
    end
  end
endmodule

// File: rtl/rename_reg_file.sv
// Architectural register file with per-register rename tags. Issue marks a
// destination busy with its ROB tag; in-order commit writes data and frees it.
module rename_reg_file
  import cpu_define::*;
#(
  parameter int XLEN_P  = XLEN,
  parameter int NREG_P  = NREG,
  parameter int REG_W_P = REG_W,
  parameter int TAG_W_P = TAG_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               clear,
  input  logic               issue_valid,
  input  logic [REG_W_P-1:0] issue_rd,
  input  logic [TAG_W_P-1:0] issue_tag,
  input  logic               commit_valid,
  input  logic [REG_W_P-1:0] commit_rd,
  input  logic [TAG_W_P-1:0] commit_tag,
  input  logic [XLEN_P-1:0]  commit_data,
  input  logic [REG_W_P-1:0] rs1_addr,
  input  logic [REG_W_P-1:0] rs2_addr,
  output logic               rs1_busy,
  output logic               rs2_busy,
  output logic [TAG_W_P-1:0] rs1_tag,
  output logic [TAG_W_P-1:0] rs2_tag,
  output logic [XLEN_P-1:0]  rs1_data,
  output logic [XLEN_P-1:0]  rs2_data
);
  localparam int NPORT = 2;

  logic [NREG_P-1:0]              reg_busy;
  logic [NREG_P-1:0][TAG_W_P-1:0] reg_tag;
  logic [NREG_P-1:0][XLEN_P-1:0]  reg_data;

  logic commit_wr, issue_wr;
  assign commit_wr = commit_valid && (commit_rd != '0);
  assign issue_wr  = issue_valid  && (issue_rd  != '0);

  // Commit frees first, then clear/issue override busy/tag: issue wins a
  // same-rd collision, clear drops any issue in its cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_busy <= '0;
      reg_tag  <= '0;
      reg_data <= '0;
    end else if (rdy) begin
      if (commit_wr) begin
        reg_data[commit_rd] <= commit_data;
        if (reg_busy[commit_rd] && (reg_tag[commit_rd] == commit_tag))
          reg_busy[commit_rd] <= READY;
      end
      if (clear) begin
        reg_busy <= '0;
      end else if (issue_wr) begin
        reg_busy[issue_rd] <= BUSY;
        reg_tag[issue_rd]  <= issue_tag;
      end
    end
  end

  logic [NPORT-1:0][REG_W_P-1:0] rd_addr;
  logic [NPORT-1:0]              rd_busy;
  logic [NPORT-1:0][TAG_W_P-1:0] rd_tag;
  logic [NPORT-1:0][XLEN_P-1:0]  rd_data;

  assign rd_addr = {rs2_addr, rs1_addr};

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    rf_read_port #(
      .XLEN_P (XLEN_P),
      .NREG_P (NREG_P),
      .REG_W_P(REG_W_P),
      .TAG_W_P(TAG_W_P)
    ) u_port (
      .addr        (rd_addr[p]),
      .reg_busy    (reg_busy),
      .reg_tag     (reg_tag),
      .reg_data    (reg_data),
      .commit_valid(commit_valid),
      .commit_rd   (commit_rd),
      .commit_tag  (commit_tag),
      .commit_data (commit_data),
      .busy        (rd_busy[p]),
      .tag         (rd_tag[p]),
      .data        (rd_data[p])
    );
  end

  assign rs1_busy = rd_busy[0];
  assign rs1_tag  = rd_tag[0];
  assign rs1_data = rd_data[0];
  assign rs2_busy = rd_busy[1];
  assign rs2_tag  = rd_tag[1];
  assign rs2_data = rd_data[1];
endmodule

// File: doc/rename_reg_file.md
# rename_reg_file

Architectural register file with per-register rename tags, sitting between the decoder/dispatch stage and the reorder buffer. At issue it marks the destination register busy with the ROB tag of the producing instruction. At commit it takes the ROB's in-order writeback (reg, tag, data), writes the data, and releases the busy mark if the tag still matches. Dispatch reads two source operands and gets either a ready value or the ROB tag to wait on.

## Interface
Parameters:
- XLEN, 32, data width
- NREG, 32, architectural registers; reg 0 is hardwired zero
- REG_W, 5, register index width (log2 NREG)
- TAG_W, 4, ROB tag width (16-entry ROB)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global enable; when low, all state holds
- clear  in  1  misprediction flush from ROB, registered one-cycle pulse
- issue_valid  in  1  an instruction with a destination is being issued this cycle
- issue_rd  in  REG_W  destination register
- issue_tag  in  TAG_W  ROB entry allocated to it
- commit_valid  in  1  ROB commit writeback valid
- commit_rd  in  REG_W  committed destination
- commit_tag  in  TAG_W  ROB entry committing
- commit_data  in  XLEN  committed value
- rs1_addr, rs2_addr  in  REG_W  source register indices from decode
- rs1_busy, rs2_busy  out  1  operand not yet available; wait on tag
- rs1_tag, rs2_tag  out  TAG_W  producing ROB tag, valid when busy
- rs1_data, rs2_data  out  XLEN  operand value, valid when not busy

## Operation
- State: data[NREG], busy[NREG], tag[NREG]. Reset clears all three to zero.
- Reg 0: writes and issues to it are ignored; reads always return busy=0, data=0.
- Commit (commit_valid, rd≠0): data[rd] <= commit_data. If busy[rd] and tag[rd]==commit_tag, busy[rd] <= 0. Otherwise busy/tag are untouched, since a younger producer owns the register.
- Issue (issue_valid, rd≠0, !clear): busy[rd] <= 1, tag[rd] <= issue_tag.
- Same cycle, same rd for issue and commit: data is written, and issue wins for busy/tag (busy=1, tag=issue_tag).
- Clear: all busy bits <= 0. Issue in the clear cycle is dropped. Commit in the clear cycle is still applied to data, because the committing instruction is older than the branch and valid (covers JALR-style commit+redirect).
- Read ports (combinational, identical per port):
  - addr==0 → busy=0, data=0, tag=0.
  - Else if commit_valid, commit_rd==addr, busy[addr], tag[addr]==commit_tag → busy=0, data=commit_data (commit bypass).
  - Else if busy[addr] → busy=1, tag=tag[addr], data=0.
  - Else → busy=0, data=data[addr], tag=0.
- Reads never see the same-cycle issue. An instruction reading its own rd gets the pre-issue mapping.
- rdy low: no state updates. Outputs still track current state combinationally.

## Timing
- Read latency 0 cycles: outputs are valid in the same cycle as the addresses.
- Writes from issue/commit are visible to reads from the next cycle. Commit is additionally visible same-cycle via the bypass.
- After rst: all outputs read busy=0, data=0, tag=0 for every address.
- Clear takes effect at the clock edge where clear is high; the next cycle reads show no busy registers.
- Reset mid-operation overrides clear, issue and commit.

## Structure
- Shared package cpu_define: XLEN, REG_W, TAG_W, Valid/Invalid and Busy/Ready constants, Null/zero constants. Same encodings as the ROB and dispatch.
- One sub-module, rf_read_port: the combinational lookup plus commit bypass. Instantiated twice (rs1, rs2).
- Storage, issue/commit/clear update logic and the x0 guard live in the top module.

## Test plan
- Reset, then read regs 0..31 → all busy=0, data=0. Commit (rd=5, tag=3, data=0x1234) with no prior issue → next cycle rs1(5) data=0x1234, busy=0.
- Issue rd=7 tag=2; next cycle rs1(7) busy=1 tag=2. Commit rd=7 tag=2 data=0xAA in a later cycle → same-cycle rs1(7) busy=0 data=0xAA (bypass), and next cycle the same from storage.
- Issue rd=7 tag=2, then issue rd=7 tag=9, then commit rd=7 tag=2 data=0x55 → rs1(7) stays busy tag=9. data[7] holds 0x55 but is not visible while busy.
- Same cycle issue rd=3 tag=4 and commit rd=3 tag=1 data=0x77 → next cycle busy=1, tag=4. Same cycle rs2_addr=3 still reads the pre-issue state.
- Busy regs 4 and 6; pulse clear together with commit rd=4 data=0x99 and issue rd=8 → next cycle all busy=0, reg4=0x99, reg8 not busy.
- Issue/commit to rd=0 with data 0xFFFF → rs1(0) busy=0 data=0. Hold rdy=0 across an issue → no state change.
